// File: rtl/intdiv_pkg.sv
// Shared constants for the SRT divider result stage.
// Entry layouts are width-dependent and typedef'd by the users.
package intdiv_pkg;

    localparam int MAX_W = 64;
    localparam logic [MAX_W-1:0] QUO_DBZ = '1;

endpackage

// File: rtl/intdiv_sync_fifo.sv
// Small synchronous FIFO holding formatted divider responses.
// Read data is forced to zero while empty.
module intdiv_sync_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; the read mux hides stale entries.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/intdiv_resp_q.sv
// Result stage for the radix-16 SRT divider: captures start context,
// formats RISC-V results (incl. divide-by-zero) and queues responses.
module intdiv_resp_q
    import intdiv_pkg::*;
#(
    parameter int D_W   = 32,
    parameter int TAG_W = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             div_start_valid_i,
    input  logic             div_start_ready_i,
    input  logic             op_is_rem_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [D_W-1:0]   dividend_i,
    input  logic             div_finish_valid_i,
    output logic             div_finish_ready_o,
    input  logic [D_W-1:0]   quotient_i,
    input  logic [D_W-1:0]   remainder_i,
    input  logic             divisor_is_zero_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [D_W-1:0]   resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             resp_dbz_o,
    output logic             unexp_finish_o
);

    typedef struct packed {
        logic [D_W-1:0]   data;
        logic [TAG_W-1:0] tag;
        logic             dbz;
    } resp_entry_t;

    localparam int EW = $bits(resp_entry_t);
    localparam int CW = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

    logic             start_hs;
    logic             finish_hs;
    logic             push;
    logic             pop;
    logic             full;
    logic [CW-1:0]    count;
    logic             pending;
    logic [TAG_W-1:0] ctx_tag;
    logic             ctx_rem;
    logic [D_W-1:0]   ctx_dividend;
    resp_entry_t      fmt;
    resp_entry_t      head;

    assign start_hs           = div_start_valid_i & div_start_ready_i;
    assign finish_hs          = div_finish_valid_i & div_finish_ready_o;
    assign div_finish_ready_o = ~full;
    assign push               = finish_hs & pending & ~flush_i;
    assign resp_valid_o       = (count != '0);
    assign pop                = resp_valid_o & resp_ready_i;

    // Start wins over a same-cycle finish; the finish used the old context.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending      <= 1'b0;
            ctx_tag      <= '0;
            ctx_rem      <= 1'b0;
            ctx_dividend <= '0;
        end else if (flush_i) begin
            pending <= 1'b0;
        end else if (start_hs) begin
            pending      <= 1'b1;
            ctx_tag      <= tag_i;
            ctx_rem      <= op_is_rem_i;
            ctx_dividend <= dividend_i;
        end else if (finish_hs) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            unexp_finish_o <= 1'b0;
        else
            unexp_finish_o <= finish_hs & ~pending & ~flush_i;
    end

    always_comb begin
        fmt     = '0;
        fmt.tag = ctx_tag;
        fmt.dbz = divisor_is_zero_i;
        if (divisor_is_zero_i)
            fmt.data = ctx_rem ? ctx_dividend : QUO_DBZ[D_W-1:0];
        else
            fmt.data = ctx_rem ? remainder_i : quotient_i;
    end

    intdiv_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .push  (push),
        .wdata (fmt),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .count (count)
    );

    assign resp_data_o = head.data;
    assign resp_tag_o  = head.tag;
    assign resp_dbz_o  = head.dbz;

endmodule

// File: tb/tb_intdiv_resp_q.sv
// Scoreboard bench for intdiv_resp_q: directed ops push expected
// responses; a monitor pops and compares on every accepted response.
module tb_intdiv_resp_q;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        div_start_valid_i;
    logic        div_start_ready_i;
    logic        op_is_rem_i;
    logic [3:0]  tag_i;
    logic [31:0] dividend_i;
    logic        div_finish_valid_i;
    logic        div_finish_ready_o;
    logic [31:0] quotient_i;
    logic [31:0] remainder_i;
    logic        divisor_is_zero_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic [3:0]  resp_tag_o;
    logic        resp_dbz_o;
    logic        unexp_finish_o;

    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];
    exp_t mon_e;
    bit   model_pend = 1'b0;

    intdiv_resp_q #(.D_W(32), .TAG_W(4), .DEPTH(2)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush_i            (flush_i),
        .div_start_valid_i  (div_start_valid_i),
        .div_start_ready_i  (div_start_ready_i),
        .op_is_rem_i        (op_is_rem_i),
        .tag_i              (tag_i),
        .dividend_i         (dividend_i),
        .div_finish_valid_i (div_finish_valid_i),
        .div_finish_ready_o (div_finish_ready_o),
        .quotient_i         (quotient_i),
        .remainder_i        (remainder_i),
        .divisor_is_zero_i  (divisor_is_zero_i),
        .resp_valid_o       (resp_valid_o),
        .resp_ready_i       (resp_ready_i),
        .resp_data_o        (resp_data_o),
        .resp_tag_o         (resp_tag_o),
        .resp_dbz_o         (resp_dbz_o),
        .unexp_finish_o     (unexp_finish_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] t, input logic rem,
                            input logic [31:0] n);
        div_start_valid_i = 1'b1;
        div_start_ready_i = 1'b1;
        tag_i             = t;
        op_is_rem_i       = rem;
        dividend_i        = n;
        tick();
        div_start_valid_i = 1'b0;
        div_start_ready_i = 1'b0;
    endtask

    task automatic do_finish(input logic [31:0] q, input logic [31:0] r,
                             input logic dbz, input bit exp_push,
                             input exp_t e);
        int n;
        div_finish_valid_i = 1'b1;
        quotient_i         = q;
        remainder_i        = r;
        divisor_is_zero_i  = dbz;
        n = 0;
        while (!div_finish_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (!div_finish_ready_o)
            chk("finish_ready_wait", div_finish_ready_o, 1);
        if (exp_push)
            sb.push_back(e);
        tick();
        div_finish_valid_i = 1'b0;
        divisor_is_zero_i  = 1'b0;
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic [3:0] t,
                                input logic z);
        exp_t e;
        e.data = d;
        e.tag  = t;
        e.dbz  = z;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && resp_valid_o && resp_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL extra_resp got tag=%0h data=%0h expected none",
                         resp_tag_o, resp_data_o);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_data", {32'h0, resp_data_o}, {32'h0, mon_e.data});
                chk("resp_tag", {60'h0, resp_tag_o}, {60'h0, mon_e.tag});
                chk("resp_dbz", {63'h0, resp_dbz_o}, {63'h0, mon_e.dbz});
            end
        end
    end

    // Protocol watch: a second start while an op is outstanding.
    always @(posedge clk) begin
        if (rst || flush_i) begin
            model_pend = 1'b0;
        end else begin
            if (div_start_valid_i && div_start_ready_i && model_pend &&
                !(div_finish_valid_i && div_finish_ready_o)) begin
                checks++;
                $display("FAIL illegal_start got start while pending expected none");
            end
            if (div_start_valid_i && div_start_ready_i)
                model_pend = 1'b1;
            else if (div_finish_valid_i && div_finish_ready_o)
                model_pend = 1'b0;
        end
    end

    initial begin
        int n;
        rst                = 1'b1;
        flush_i            = 1'b0;
        div_start_valid_i  = 1'b0;
        div_start_ready_i  = 1'b0;
        op_is_rem_i        = 1'b0;
        tag_i              = '0;
        dividend_i         = '0;
        div_finish_valid_i = 1'b0;
        quotient_i         = '0;
        remainder_i        = '0;
        divisor_is_zero_i  = 1'b0;
        resp_ready_i       = 1'b1;
        #1;
        chk("rst_valid", resp_valid_o, 0);
        chk("rst_fin_ready", div_finish_ready_o, 1);
        chk("rst_unexp", unexp_finish_o, 0);
        chk("rst_data", resp_data_o, 0);
        chk("rst_tag", resp_tag_o, 0);
        chk("rst_dbz", resp_dbz_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Plain quotient with one-cycle latency.
        do_start(4'd3, 1'b0, 32'd100);
        do_finish(32'd7, 32'd2, 1'b0, 1, mk(32'd7, 4'd3, 1'b0));
        chk("lat_valid", resp_valid_o, 1);
        chk("lat_data", resp_data_o, 32'd7);
        tick();

        // Divide by zero: remainder returns dividend, quotient all ones.
        do_start(4'd5, 1'b1, 32'h8000_0000);
        do_finish(32'h1234, 32'h5678, 1'b1, 1,
                  mk(32'h8000_0000, 4'd5, 1'b1));
        do_start(4'd6, 1'b0, 32'h8000_0000);
        do_finish(32'h1234, 32'h5678, 1'b1, 1,
                  mk(32'hFFFF_FFFF, 4'd6, 1'b1));
        tick();

        // Signed overflow passes through; remainder select.
        do_start(4'd2, 1'b1, 32'h8000_0000);
        do_finish(32'h8000_0000, 32'd0, 1'b0, 1, mk(32'd0, 4'd2, 1'b0));
        tick();

        // Backpressure: full after two pushes, drain in order.
        resp_ready_i = 1'b0;
        do_start(4'd1, 1'b0, 32'd10);
        do_finish(32'd11, 32'd0, 1'b0, 1, mk(32'd11, 4'd1, 1'b0));
        do_start(4'd2, 1'b0, 32'd20);
        do_finish(32'd22, 32'd0, 1'b0, 1, mk(32'd22, 4'd2, 1'b0));
        chk("full_ready", div_finish_ready_o, 0);
        chk("full_hold_tag", resp_tag_o, 4'd1);
        do_start(4'd3, 1'b0, 32'd30);
        resp_ready_i = 1'b1;
        do_finish(32'd33, 32'd0, 1'b0, 1, mk(32'd33, 4'd3, 1'b0));
        repeat (4) tick();

        // Start and finish in the same cycle.
        do_start(4'd7, 1'b0, 32'd50);
        div_start_valid_i = 1'b1;
        div_start_ready_i = 1'b1;
        tag_i             = 4'd8;
        do_finish(32'd9, 32'd0, 1'b0, 1, mk(32'd9, 4'd7, 1'b0));
        div_start_valid_i = 1'b0;
        div_start_ready_i = 1'b0;
        do_finish(32'd10, 32'd0, 1'b0, 1, mk(32'd10, 4'd8, 1'b0));
        repeat (3) tick();

        // Finish with nothing pending.
        do_finish(32'd99, 32'd0, 1'b0, 0, mk(32'd0, 4'd0, 1'b0));
        chk("unexp_pulse", unexp_finish_o, 1);
        chk("unexp_no_resp", resp_valid_o, 0);
        tick();
        chk("unexp_clear", unexp_finish_o, 0);

        // Flush with two buffered entries and one op pending.
        resp_ready_i = 1'b0;
        do_start(4'd1, 1'b0, 32'd1);
        do_finish(32'd1, 32'd0, 1'b0, 0, mk(32'd0, 4'd0, 1'b0));
        do_start(4'd2, 1'b0, 32'd2);
        do_finish(32'd2, 32'd0, 1'b0, 0, mk(32'd0, 4'd0, 1'b0));
        do_start(4'd3, 1'b0, 32'd3);
        chk("pre_flush_valid", resp_valid_o, 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_valid", resp_valid_o, 0);
        chk("flush_fin_ready", div_finish_ready_o, 1);
        resp_ready_i = 1'b1;
        do_finish(32'd3, 32'd0, 1'b0, 0, mk(32'd0, 4'd0, 1'b0));
        chk("flush_unexp", unexp_finish_o, 1);
        tick();

        // Asynchronous reset mid-stream.
        resp_ready_i = 1'b0;
        do_start(4'd4, 1'b0, 32'd4);
        do_finish(32'd4, 32'd0, 1'b0, 0, mk(32'd0, 4'd0, 1'b0));
        do_start(4'd5, 1'b0, 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", resp_valid_o, 0);
        chk("arst_data", resp_data_o, 0);
        chk("arst_tag", resp_tag_o, 0);
        chk("arst_fin_ready", div_finish_ready_o, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        resp_ready_i = 1'b1;
        do_finish(32'd6, 32'd0, 1'b0, 0, mk(32'd0, 4'd0, 1'b0));
        chk("arst_unexp", unexp_finish_o, 1);
        do_start(4'd9, 1'b0, 32'd88);
        do_finish(32'd44, 32'd0, 1'b0, 1, mk(32'd44, 4'd9, 1'b0));

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
